// File: rtl/mesh_edge_injector_if.sv
// Edge-port bundle: packet source handshake on one side, mesh edge flit port on the other.
interface mesh_edge_injector_if #(
   parameter int unsigned FLIT_WIDTH = 4,
   parameter int unsigned PKT_WIDTH  = 16
);
   logic [PKT_WIDTH-1:0]  pkt_in;
   logic                  pkt_valid;
   logic                  pkt_ready;
   logic [FLIT_WIDTH-1:0] flit_out;
   logic                  flit_en;
   logic                  port_full;
   logic                  busy;
   logic [7:0]            sent_count;

   modport master (
      output pkt_in, pkt_valid, port_full,
      input  pkt_ready, flit_out, flit_en, busy, sent_count
   );

   modport slave (
      input  pkt_in, pkt_valid, port_full,
      output pkt_ready, flit_out, flit_en, busy, sent_count
   );
endinterface

// File: rtl/mesh_edge_injector.sv
// Buffers whole spike packets in a small FIFO and serializes each into
// MSB-first flits on a mesh edge port, stalling while the port is full.
module mesh_edge_injector #(
   parameter int unsigned FLIT_WIDTH    = 4,
   parameter int unsigned FLITS_PER_PKT = 4,
   parameter int unsigned PKT_WIDTH     = 16,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned FIFO_AW       = 2
) (
   input logic                  rt_clk,
   input logic                  rt_reset,
   mesh_edge_injector_if.slave  edge_bus
);
   localparam int unsigned IDX_W = (FLITS_PER_PKT > 1) ? $clog2(FLITS_PER_PKT) : 1;
   localparam int unsigned CNT_W = FIFO_AW + 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   logic [0:0]           state, state_nxt;
   logic [PKT_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]     count;
   logic [PKT_WIDTH-1:0] shreg, shreg_nxt;
   logic [IDX_W-1:0]     idx, idx_nxt;
   logic [7:0]           sent, sent_nxt;
   logic                 push, pop;

   assign push = edge_bus.pkt_valid & edge_bus.pkt_ready;

   assign edge_bus.pkt_ready  = (count != CNT_W'(FIFO_DEPTH));
   assign edge_bus.busy       = (count != '0) | (state == SEND);
   assign edge_bus.flit_en    = (state == SEND) & ~edge_bus.port_full & ~rt_reset;
   assign edge_bus.flit_out   = shreg[PKT_WIDTH-1 -: FLIT_WIDTH];
   assign edge_bus.sent_count = sent;

   // FIFO storage carries no reset; validity lives in the pointers and count.
   always_ff @(posedge rt_clk) begin
      if (push) mem[wr_ptr] <= edge_bus.pkt_in;
   end

   always_ff @(posedge rt_clk) begin
      if (rt_reset) begin
         state  <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         shreg  <= '0;
         idx    <= '0;
         sent   <= '0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         idx   <= idx_nxt;
         sent  <= sent_nxt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Pop in IDLE (no fall-through), then one flit per cycle the port accepts.
   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      idx_nxt   = idx;
      sent_nxt  = sent;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop       = 1'b1;
               shreg_nxt = mem[rd_ptr];
               idx_nxt   = '0;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (!edge_bus.port_full) begin
               shreg_nxt = {shreg[PKT_WIDTH-FLIT_WIDTH-1:0], {FLIT_WIDTH{1'b0}}};
               idx_nxt   = idx + 1'b1;
               if (idx == IDX_W'(FLITS_PER_PKT - 1)) begin
                  state_nxt = IDLE;
                  sent_nxt  = sent + 8'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule
